// File: rtl/sdram_arbiter_pkg.sv
// Shared SDRAM command codes, NOP bus values and arbiter state encoding.
package sdram_arbiter_pkg;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] OP_MRS   = 4'b0000;
    localparam logic [3:0] OP_AREF  = 4'b0001;
    localparam logic [3:0] OP_PRECH = 4'b0010;
    localparam logic [3:0] OP_ACT   = 4'b0011;
    localparam logic [3:0] OP_WRITE = 4'b0100;
    localparam logic [3:0] OP_READ  = 4'b0101;
    localparam logic [3:0] OP_BSTOP = 4'b0110;
    localparam logic [3:0] OP_NOP   = 4'b0111;

    localparam logic [1:0]  NOP_BA   = 2'b11;
    localparam logic [12:0] NOP_ADDR = 13'h1fff;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_AREF  = 3'd2,
        ST_WRITE = 3'd3,
        ST_READ  = 3'd4
    } arb_state_t;

    // Refresh interval in clock cycles: TREFI[ns] * f[MHz] / 1000.
    function automatic int unsigned cnt_ref(int unsigned clk_hz, int unsigned trefi_ns);
        return trefi_ns * (clk_hz / 1_000_000) / 1000;
    endfunction

endpackage

// File: rtl/sdram_arbiter_if.sv
// Engine-side and pin-side signals of the SDRAM arbiter.
// master: the init/aref/write/read engines and pin consumer; slave: the arbiter.
interface sdram_arbiter_if;
    logic [3:0]  init_cmd;
    logic [1:0]  init_ba;
    logic [12:0] init_addr;
    logic        init_end;
    logic [3:0]  aref_cmd;
    logic        aref_en;
    logic        aref_end;
    logic        wr_req;
    logic [3:0]  wr_cmd;
    logic [1:0]  wr_ba;
    logic [12:0] wr_addr;
    logic        wr_en;
    logic        wr_end;
    logic        rd_req;
    logic [3:0]  rd_cmd;
    logic [1:0]  rd_ba;
    logic [12:0] rd_addr;
    logic        rd_en;
    logic        rd_end;
    logic        aref_due;
    logic [3:0]  sdram_cmd;
    logic [1:0]  sdram_ba;
    logic [12:0] sdram_addr;

    modport master (
        output init_cmd, init_ba, init_addr, init_end,
        output aref_cmd, aref_end,
        output wr_req, wr_cmd, wr_ba, wr_addr, wr_end,
        output rd_req, rd_cmd, rd_ba, rd_addr, rd_end,
        input  aref_en, wr_en, rd_en, aref_due,
        input  sdram_cmd, sdram_ba, sdram_addr
    );

    modport slave (
        input  init_cmd, init_ba, init_addr, init_end,
        input  aref_cmd, aref_end,
        input  wr_req, wr_cmd, wr_ba, wr_addr, wr_end,
        input  rd_req, rd_cmd, rd_ba, rd_addr, rd_end,
        output aref_en, wr_en, rd_en, aref_due,
        output sdram_cmd, sdram_ba, sdram_addr
    );
endinterface

// File: rtl/sdram_arbiter_ref_timer.sv
// sdram_ref_timer: free-running refresh interval counter and the sticky
// refresh-pending flag. Counter is held at zero until init completes.
module sdram_ref_timer #(
    parameter int unsigned CNT_REF = 780
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic ack,
    output logic aref_due
);
    localparam logic [15:0] CNT_MAX = 16'(CNT_REF - 1);

    logic [15:0] cnt;
    logic        wrap;

    assign wrap = (cnt == CNT_MAX);

    // Interval counter: 0..CNT_REF-1, wraps forever once enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        cnt <= '0;
        else if (!enable)  cnt <= '0;
        else if (wrap)     cnt <= '0;
        else               cnt <= cnt + 16'd1;
    end

    // Pending flag: set on wrap (set wins so a refresh is never lost), cleared by the grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               aref_due <= 1'b0;
        else if (enable && wrap)  aref_due <= 1'b1;
        else if (ack)             aref_due <= 1'b0;
    end
endmodule

// File: rtl/sdram_arbiter.sv
// SDRAM command-bus arbiter: init sequencer first, then auto-refresh, write
// and read engines. Refresh has top priority; write/read priority is fixed
// (write first) unless SDRAM_ARB_RR_EN is defined, which alternates them.
import sdram_arbiter_pkg::*;

module sdram_arbiter #(
    parameter int unsigned CLK   = 100_000_000,
    parameter int unsigned TREFI = 7800
) (
    input logic            clk,
    input logic            rst_n,
    sdram_arbiter_if.slave bus
);
    arb_state_t state;
    logic       aref_due;
    logic       wr_win;

    sdram_ref_timer #(.CNT_REF(cnt_ref(CLK, TREFI))) u_ref_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (bus.init_end),
        .ack      (bus.aref_en),
        .aref_due (aref_due)
    );

    assign bus.aref_due = aref_due;

`ifdef SDRAM_ARB_RR_EN
    // 0 = read won the last contested grant, 1 = write did.
    logic last_grant;
    assign wr_win = bus.wr_req && (!bus.rd_req || !last_grant);
`else
    assign wr_win = bus.wr_req;
`endif

    // Arbiter FSM; grant pulses are registered so they line up with the first cycle of the new state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_INIT;
            bus.aref_en <= 1'b0;
            bus.wr_en   <= 1'b0;
            bus.rd_en   <= 1'b0;
`ifdef SDRAM_ARB_RR_EN
            last_grant  <= 1'b0;
`endif
        end else begin
            bus.aref_en <= 1'b0;
            bus.wr_en   <= 1'b0;
            bus.rd_en   <= 1'b0;
            case (state)
                ST_INIT: if (bus.init_end) state <= ST_IDLE;
                ST_IDLE: begin
                    if (aref_due) begin
                        state       <= ST_AREF;
                        bus.aref_en <= 1'b1;
                    end else if (wr_win) begin
                        state     <= ST_WRITE;
                        bus.wr_en <= 1'b1;
                    end else if (bus.rd_req) begin
                        state     <= ST_READ;
                        bus.rd_en <= 1'b1;
                    end
`ifdef SDRAM_ARB_RR_EN
                    // Only contested grants flip the priority, so uncontested traffic cannot starve the other side.
                    if (!aref_due && bus.wr_req && bus.rd_req) last_grant <= wr_win;
`endif
                end
                ST_AREF:  if (bus.aref_end) state <= ST_IDLE;
                ST_WRITE: if (bus.wr_end)   state <= ST_IDLE;
                ST_READ:  if (bus.rd_end)   state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // Pin mux selected by the current owner; async reset forces INIT and so the init_* path.
    always_comb begin
        bus.sdram_cmd  = OP_NOP;
        bus.sdram_ba   = NOP_BA;
        bus.sdram_addr = NOP_ADDR;
        case (state)
            ST_INIT: begin
                bus.sdram_cmd  = bus.init_cmd;
                bus.sdram_ba   = bus.init_ba;
                bus.sdram_addr = bus.init_addr;
            end
            ST_AREF: bus.sdram_cmd = bus.aref_cmd;
            ST_WRITE: begin
                bus.sdram_cmd  = bus.wr_cmd;
                bus.sdram_ba   = bus.wr_ba;
                bus.sdram_addr = bus.wr_addr;
            end
            ST_READ: begin
                bus.sdram_cmd  = bus.rd_cmd;
                bus.sdram_ba   = bus.rd_ba;
                bus.sdram_addr = bus.rd_addr;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: table-driven write/read vectors plus
// hand sequences for init, refresh timing, refresh mid-write and async reset.
import sdram_arbiter_pkg::*;

module tb_sdram_arbiter;
    logic clk;
    logic rst_n;

    sdram_arbiter_if ifc ();

    sdram_arbiter #(.CLK(100_000_000), .TREFI(7800)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [1:0]  WR_BA   = 2'b01;
    localparam logic [12:0] WR_ADDR = 13'h0aaa;
    localparam logic [1:0]  RD_BA   = 2'b10;
    localparam logic [12:0] RD_ADDR = 13'h0555;
    localparam int unsigned REF_CYC = 780;

`ifdef SDRAM_ARB_RR_EN
    localparam arb_state_t RPT_ST = ST_READ;
    localparam logic RPT_WE = 1'b0, RPT_RE = 1'b1;
`else
    localparam arb_state_t RPT_ST = ST_WRITE;
    localparam logic RPT_WE = 1'b1, RPT_RE = 1'b0;
`endif

    typedef struct packed {
        logic [3:0]  cmd;
        logic [1:0]  ba;
        logic [12:0] addr;
        logic        aref_en;
        logic        wr_en;
        logic        rd_en;
        logic        due;
    } obs_t;

    typedef struct {
        logic       wr_req, rd_req, wr_end, rd_end, aref_end;
        arb_state_t st;
        logic       we, re;
    } vec_t;

    obs_t  sb_q[$];
    string nm_q[$];
    int    vectors = 0;
    int    miscompares = 0;

    // Expected pin/handshake values for a given owner.
    function automatic obs_t mk(arb_state_t s, logic ae, logic we, logic re, logic due);
        obs_t o;
        o.aref_en = ae; o.wr_en = we; o.rd_en = re; o.due = due;
        o.cmd = OP_NOP; o.ba = NOP_BA; o.addr = NOP_ADDR;
        case (s)
            ST_INIT:  begin o.cmd = ifc.init_cmd; o.ba = ifc.init_ba; o.addr = ifc.init_addr; end
            ST_AREF:  o.cmd = OP_AREF;
            ST_WRITE: begin o.cmd = OP_WRITE; o.ba = WR_BA; o.addr = WR_ADDR; end
            ST_READ:  begin o.cmd = OP_READ;  o.ba = RD_BA; o.addr = RD_ADDR; end
            default:  ;
        endcase
        return o;
    endfunction

    function automatic obs_t cur();
        obs_t o;
        o.cmd = ifc.sdram_cmd; o.ba = ifc.sdram_ba; o.addr = ifc.sdram_addr;
        o.aref_en = ifc.aref_en; o.wr_en = ifc.wr_en; o.rd_en = ifc.rd_en; o.due = ifc.aref_due;
        return o;
    endfunction

    task automatic expect_out(input string nm, input obs_t e);
        sb_q.push_back(e);
        nm_q.push_back(nm);
    endtask

    task automatic drain();
        obs_t  e, g;
        string nm;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            nm = nm_q.pop_front();
            g = cur();
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL %s: got cmd=%h ba=%h addr=%h a/w/r_en=%b%b%b due=%b, want cmd=%h ba=%h addr=%h a/w/r_en=%b%b%b due=%b",
                         nm, g.cmd, g.ba, g.addr, g.aref_en, g.wr_en, g.rd_en, g.due,
                         e.cmd, e.ba, e.addr, e.aref_en, e.wr_en, e.rd_en, e.due);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic chk_int(input string nm, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", nm, got, exp);
        end
    endtask

    // Steps until aref_due rises (bounded) and returns the number of edges taken.
    task automatic wait_due(output int n);
        n = 0;
        while (ifc.aref_due !== 1'b1 && n < 2000) begin
            step();
            n++;
        end
    endtask

    vec_t tbl[11];
    int   n;

    initial begin
        tbl[0]  = '{1, 1, 0, 0, 0, ST_WRITE, 1, 0};
        tbl[1]  = '{0, 1, 0, 0, 0, ST_WRITE, 0, 0};
        tbl[2]  = '{0, 1, 0, 1, 0, ST_WRITE, 0, 0};   // stray rd_end
        tbl[3]  = '{0, 1, 1, 0, 0, ST_IDLE,  0, 0};
        tbl[4]  = '{0, 1, 0, 0, 0, ST_READ,  0, 1};
        tbl[5]  = '{0, 0, 0, 0, 0, ST_READ,  0, 0};
        tbl[6]  = '{0, 0, 0, 1, 0, ST_IDLE,  0, 0};
        tbl[7]  = '{1, 1, 0, 0, 0, RPT_ST,   RPT_WE, RPT_RE};
        tbl[8]  = '{0, 0, 0, 0, 0, RPT_ST,   0, 0};
        tbl[9]  = '{0, 0, 1, 1, 0, ST_IDLE,  0, 0};
        tbl[10] = '{0, 0, 0, 0, 0, ST_IDLE,  0, 0};

        rst_n = 1'b0;
        ifc.init_cmd = OP_NOP; ifc.init_ba = NOP_BA; ifc.init_addr = NOP_ADDR; ifc.init_end = 1'b0;
        ifc.aref_cmd = OP_AREF; ifc.aref_end = 1'b0;
        ifc.wr_req = 1'b0; ifc.wr_cmd = OP_WRITE; ifc.wr_ba = WR_BA; ifc.wr_addr = WR_ADDR; ifc.wr_end = 1'b0;
        ifc.rd_req = 1'b0; ifc.rd_cmd = OP_READ;  ifc.rd_ba = RD_BA; ifc.rd_addr = RD_ADDR; ifc.rd_end = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        expect_out("reset_state", mk(ST_INIT, 0, 0, 0, 0));
        drain();
        rst_n = 1'b1;

        // Init phase: pins follow a changing init_* stream until init_end.
        for (int i = 0; i < 50; i++) begin
            ifc.init_cmd  = (i % 3 == 0) ? OP_PRECH : (i % 3 == 1) ? OP_AREF : OP_MRS;
            ifc.init_ba   = 2'(i);
            ifc.init_addr = 13'(i * 37);
            expect_out("init_follow", mk(ST_INIT, 0, 0, 0, 0));
            step();
        end
        ifc.init_end = 1'b1;
        ifc.init_cmd = OP_NOP; ifc.init_ba = NOP_BA; ifc.init_addr = NOP_ADDR;
        expect_out("init_to_idle", mk(ST_IDLE, 0, 0, 0, 0));
        step();

        // First refresh: due exactly REF_CYC edges after init_end, grant next cycle.
        wait_due(n);
        chk_int("due_latency", n + 1, REF_CYC);
        expect_out("aref_grant", mk(ST_AREF, 1, 0, 0, 1));
        step();
        expect_out("aref_due_clr", mk(ST_AREF, 0, 0, 0, 0));
        step();
        ifc.aref_end = 1'b1;
        expect_out("aref_done", mk(ST_IDLE, 0, 0, 0, 0));
        step();
        ifc.aref_end = 1'b0;

        // Write/read contention, stray end, repeat pattern.
        for (int i = 0; i < 11; i++) begin
            ifc.wr_req = tbl[i].wr_req; ifc.rd_req = tbl[i].rd_req;
            ifc.wr_end = tbl[i].wr_end; ifc.rd_end = tbl[i].rd_end; ifc.aref_end = tbl[i].aref_end;
            expect_out($sformatf("tbl%0d", i), mk(tbl[i].st, 0, tbl[i].we, tbl[i].re, 0));
            step();
        end
        ifc.wr_req = 0; ifc.rd_req = 0; ifc.wr_end = 0; ifc.rd_end = 0; ifc.aref_end = 0;

        // Refresh falls due mid-write: no preemption, then AREF beats pending read.
        ifc.wr_req = 1'b1;
        expect_out("mw_grant", mk(ST_WRITE, 0, 1, 0, 0));
        step();
        ifc.wr_req = 1'b0;
        wait_due(n);
        expect_out("due_midwrite", mk(ST_WRITE, 0, 0, 0, 1));
        drain();
        for (int i = 0; i < 3; i++) begin
            expect_out("mw_hold", mk(ST_WRITE, 0, 0, 0, 1));
            step();
        end
        ifc.rd_req = 1'b1; ifc.wr_end = 1'b1;
        expect_out("mw_end", mk(ST_IDLE, 0, 0, 0, 1));
        step();
        ifc.wr_end = 1'b0;
        expect_out("mw_aref_first", mk(ST_AREF, 1, 0, 0, 1));
        step();
        expect_out("mw_aref", mk(ST_AREF, 0, 0, 0, 0));
        step();
        ifc.aref_end = 1'b1;
        expect_out("mw_aref_done", mk(ST_IDLE, 0, 0, 0, 0));
        step();
        ifc.aref_end = 1'b0;
        expect_out("mw_read", mk(ST_READ, 0, 0, 1, 0));
        step();
        ifc.rd_req = 1'b0;
        expect_out("mw_read_hold", mk(ST_READ, 0, 0, 0, 0));
        step();

        // Async reset during READ.
        rst_n = 1'b0;
        ifc.init_end = 1'b0;
        #1;
        expect_out("rst_midread", mk(ST_INIT, 0, 0, 0, 0));
        drain();
        for (int i = 0; i < 2; i++) begin
            expect_out("rst_hold", mk(ST_INIT, 0, 0, 0, 0));
            step();
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            expect_out("post_rst_init", mk(ST_INIT, 0, 0, 0, 0));
            step();
        end
        ifc.init_end = 1'b1;
        expect_out("reinit_idle", mk(ST_IDLE, 0, 0, 0, 0));
        step();
        wait_due(n);
        chk_int("due_latency_reinit", n + 1, REF_CYC);
        expect_out("reinit_aref", mk(ST_AREF, 1, 0, 0, 1));
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
